// File: rtl/calc_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared registered calculator
// datapath: grants one request, holds its operands for LAT cycles, returns the tagged result.
module calc_arbiter #(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [3:0]     req_op0,
  input  logic [3:0]     req_op1,
  input  logic [N-1:0]   req_a0,
  input  logic [N-1:0]   req_a1,
  input  logic [N-1:0]   req_b0,
  input  logic [N-1:0]   req_b1,
  output logic [3:0]     calc_op,
  output logic [N-1:0]   calc_a,
  output logic [N-1:0]   calc_b,
  output logic           calc_issue,
  input  logic [2*N-1:0] calc_result,
  input  logic [3:0]     calc_flags,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*N-1:0] rsp_result,
  output logic [3:0]     rsp_flags,
  output logic           busy
);

  localparam int unsigned RW    = 2 * N;
  localparam int unsigned OPW   = 4;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_d;
  logic               prio, prio_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [OPW-1:0]     op_d;
  logic [N-1:0]       a_d, b_d;
  logic               id_d;
  logic [RW-1:0]      res_d;
  logic [3:0]         flg_d;
  logic               grant;

  // Pointer only breaks ties; a lone requester always wins.
  assign grant = (req_valid == 2'b11) ? prio : req_valid[1];

  // Next-state, grant strobe and data captures.
  always_comb begin
    state_d   = state;
    prio_d    = prio;
    cnt_d     = cnt;
    op_d      = calc_op;
    a_d       = calc_a;
    b_d       = calc_b;
    id_d      = rsp_id;
    res_d     = rsp_result;
    flg_d     = rsp_flags;
    req_ready = 2'b00;
    case (state)
      IDLE: begin
        if ((req_valid != 2'b00) && !reset) begin
          req_ready = grant ? 2'b10 : 2'b01;
          op_d      = grant ? req_op1 : req_op0;
          a_d       = grant ? req_a1 : req_a0;
          b_d       = grant ? req_b1 : req_b0;
          id_d      = grant;
          prio_d    = ~grant;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt == '0) begin
          res_d   = calc_result;
          flg_d   = calc_flags;
          state_d = RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; status strobes are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      cnt        <= '0;
      calc_op    <= '0;
      calc_a     <= '0;
      calc_b     <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      calc_issue <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      prio       <= prio_d;
      cnt        <= cnt_d;
      calc_op    <= op_d;
      calc_a     <= a_d;
      calc_b     <= b_d;
      rsp_id     <= id_d;
      rsp_result <= res_d;
      rsp_flags  <= flg_d;
      calc_issue <= (state_d == ISSUE);
      rsp_valid  <= (state_d == RESP);
      busy       <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_calc_arbiter.sv
// Bench for calc_arbiter: transaction-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic and resets.
module tb_calc_arbiter;

  localparam int unsigned N   = 8;
  localparam int unsigned LAT = 2;
  localparam int unsigned RW  = 2 * N;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid, req_ready;
  logic [3:0]    req_op0, req_op1;
  logic [N-1:0]  req_a0, req_a1, req_b0, req_b1;
  logic [3:0]    calc_op;
  logic [N-1:0]  calc_a, calc_b;
  logic          calc_issue;
  logic [RW-1:0] calc_result;
  logic [3:0]    calc_flags;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [RW-1:0] rsp_result;
  logic [3:0]    rsp_flags;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  calc_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b), .calc_issue(calc_issue),
    .calc_result(calc_result), .calc_flags(calc_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] alu_res(input logic [3:0] op, input logic [N-1:0] a,
                                            input logic [N-1:0] b);
    case (op)
      4'd0:    return RW'(a) + RW'(b);
      4'd1:    return RW'(a) - RW'(b);
      4'd2:    return RW'(a) * RW'(b);
      4'd3:    return RW'(a & b);
      default: return RW'(a ^ b);
    endcase
  endfunction

  function automatic logic [3:0] alu_flg(input logic [RW-1:0] r);
    return {r[RW-1], ^r, 1'b0, (r == '0)};
  endfunction

  // Datapath stand-in: input register then output register (LAT = 2).
  logic [3:0]   dp_op;
  logic [N-1:0] dp_a, dp_b;
  always @(posedge clk) begin
    dp_op       <= calc_op;
    dp_a        <= calc_a;
    dp_b        <= calc_b;
    calc_result <= alu_res(dp_op, dp_a, dp_b);
    calc_flags  <= alu_flg(alu_res(dp_op, dp_a, dp_b));
  end

  // Reference model: one outstanding transaction, timed from its accept cycle.
  bit            armed  = 1'b0;
  bit            m_have = 1'b0;
  bit            m_prio = 1'b0;
  bit            m_id   = 1'b0;
  int            m_acc  = 0;
  logic [3:0]    m_op   = '0;
  logic [N-1:0]  m_a    = '0;
  logic [N-1:0]  m_b    = '0;
  logic [RW-1:0] m_res  = '0;
  logic [3:0]    m_flg  = '0;

  always @(negedge clk) begin
    bit       g;
    bit       e_val;
    logic [1:0] e_rdy;
    g     = (req_valid == 2'b11) ? m_prio : req_valid[1];
    e_rdy = (!reset && !m_have && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
    e_val = m_have && (cyc >= m_acc + 2 + int'(LAT));
    if (armed) begin
      chk("req_ready",  32'(req_ready),  32'(e_rdy));
      chk("calc_issue", 32'(calc_issue), 32'(m_have && (cyc == m_acc + 1)));
      chk("rsp_valid",  32'(rsp_valid),  32'(e_val));
      chk("busy",       32'(busy),       32'(m_have));
      chk("calc_op",    32'(calc_op),    32'(m_op));
      chk("calc_a",     32'(calc_a),     32'(m_a));
      chk("calc_b",     32'(calc_b),     32'(m_b));
      chk("rsp_id",     32'(rsp_id),     32'(m_id));
      if (e_val) begin
        chk("rsp_result", 32'(rsp_result), 32'(m_res));
        chk("rsp_flags",  32'(rsp_flags),  32'(m_flg));
      end
    end
    if (reset) begin
      m_have = 1'b0; m_prio = 1'b0; m_id = 1'b0;
      m_op = '0; m_a = '0; m_b = '0;
      armed = 1'b1;
    end else if (e_rdy != 2'b00) begin
      m_have = 1'b1;
      m_acc  = cyc;
      m_prio = ~g;
      m_id   = g;
      m_op   = g ? req_op1 : req_op0;
      m_a    = g ? req_a1 : req_a0;
      m_b    = g ? req_b1 : req_b0;
      m_res  = alu_res(m_op, m_a, m_b);
      m_flg  = alu_flg(m_res);
    end else if (e_val && rsp_ready) begin
      m_have = 1'b0;
    end
  end

  // Runs until one response handshake; records accept/issue/response cycles.
  task automatic run_op(input bit here, input logic [1:0] drop_mask,
                        output int acc, output int iss, output int rc,
                        output logic id, output logic [RW-1:0] res, output logic [3:0] flg);
    bit drop = 1'b0;
    bit done = 1'b0;
    acc = -1; iss = -1; rc = -1; id = 1'b0; res = '0; flg = '0;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        if (drop) begin
          req_valid = req_valid & ~drop_mask;
          drop = 1'b0;
        end
        @(negedge clk);
      end else if (!here) begin
        @(negedge clk);
      end
      if (req_ready != 2'b00 && acc < 0) begin acc = cyc; drop = 1'b1; end
      if (calc_issue && iss < 0) iss = cyc;
      if (rsp_valid && rsp_ready) begin
        rc = cyc; id = rsp_id; res = rsp_result; flg = rsp_flags; done = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL run_op_timeout: got no response expected one within 60 cycles");
    end
  endtask

  initial begin
    int a1, i1, r1, a2, i2, r2;
    logic id1, id2;
    logic [RW-1:0] res1, res2;
    logic [3:0] f1, f2;
    bit found;
    logic s_id;
    logic [RW-1:0] s_res;
    logic [3:0] s_flg;
    logic [N-1:0] s_a, s_b;

    // Reset with both requesters pending, then contention.
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req_op0 = 4'd0; req_a0 = 8'd3; req_b0 = 8'd4;
    req_op1 = 4'd0; req_a1 = 8'd0; req_b1 = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_calc_issue", 32'(calc_issue), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_calc_a",     32'(calc_a),     32'd0);
    chk("rst_calc_b",     32'(calc_b),     32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_req_ready",  32'(req_ready),  32'b01);
    run_op(1'b1, 2'b00, a1, i1, r1, id1, res1, f1);
    run_op(1'b0, 2'b11, a2, i2, r2, id2, res2, f2);
    chk("cont_id0",      32'(id1),   32'd0);
    chk("cont_res0",     32'(res1),  32'd7);
    chk("cont_id1",      32'(id2),   32'd1);
    chk("cont_res1",     32'(res2),  32'd0);
    chk("cont_zero1",    32'(f2[0]), 32'd1);
    chk("cont_spacing",  32'(a2 - a1), 32'd5);

    // Single request from requester 0: 12*10.
    @(posedge clk); #1;
    req_valid = 2'b01; req_op0 = 4'd2; req_a0 = 8'd12; req_b0 = 8'd10;
    run_op(1'b0, 2'b11, a1, i1, r1, id1, res1, f1);
    chk("single_issue_lat", 32'(i1 - a1), 32'd1);
    chk("single_rsp_lat",   32'(r1 - a1), 32'd4);
    chk("single_res",       32'(res1),    32'd120);
    chk("single_id",        32'(id1),     32'd0);
    chk("single_zero",      32'(f1[0]),   32'd0);

    // Backpressure: response held for 5 extra cycles with both requesters waiting.
    @(posedge clk); #1;
    req_valid = 2'b11; rsp_ready = 1'b0;
    req_op0 = 4'd1; req_a0 = 8'd50; req_b0 = 8'd20;
    req_op1 = 4'd3; req_a1 = 8'hF0; req_b1 = 8'h3C;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
    end
    chk("bp_rsp_seen", 32'(found), 32'd1);
    s_id = rsp_id; s_res = rsp_result; s_flg = rsp_flags; s_a = calc_a; s_b = calc_b;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_id",    32'(rsp_id),     32'(s_id));
      chk("bp_rsp_res",   32'(rsp_result), 32'(s_res));
      chk("bp_rsp_flags", 32'(rsp_flags),  32'(s_flg));
      chk("bp_calc_a",    32'(calc_a),     32'(s_a));
      chk("bp_calc_b",    32'(calc_b),     32'(s_b));
      chk("bp_req_ready", 32'(req_ready),  32'b00);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    chk("bp_idle_busy",  32'(busy),      32'd0);
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);

    // Reset during the first WAIT cycle after granting requester 0.
    @(posedge clk); #1;
    req_valid = 2'b01; req_op0 = 4'd0; req_a0 = 8'd9; req_b0 = 8'd9;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) found = 1'b1;
    end
    chk("mid_accept", 32'(found), 32'd1);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk);
    chk("mid_issue", 32'(calc_issue), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_wait_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_busy",   32'(busy),      32'd0);
    chk("mid_valid",  32'(rsp_valid), 32'd0);
    chk("mid_calc_a", 32'(calc_a),    32'd0);
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("mid_prio_reset", 32'(req_ready), 32'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    run_op(1'b0, 2'b00, a1, i1, r1, id1, res1, f1);
    chk("mid_next_res", 32'(res1), 32'd18);
    chk("mid_next_id",  32'(id1),  32'd0);

    // Requester 1 back-to-back: 200*200 twice.
    @(posedge clk); #1;
    req_valid = 2'b10; req_op1 = 4'd2; req_a1 = 8'd200; req_b1 = 8'd200;
    run_op(1'b0, 2'b00, a1, i1, r1, id1, res1, f1);
    run_op(1'b0, 2'b11, a2, i2, r2, id2, res2, f2);
    chk("b2b_res0",    32'(res1),     32'd40000);
    chk("b2b_id0",     32'(id1),      32'd1);
    chk("b2b_res1",    32'(res2),     32'd40000);
    chk("b2b_id1",     32'(id2),      32'd1);
    chk("b2b_spacing", 32'(a2 - a1),  32'd5);
    @(posedge clk); #1 req_valid = 2'b11;
    @(negedge clk);
    chk("b2b_prio", 32'(req_ready), 32'b01);

    // Randomized traffic, backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 199) == 0);
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_op0   = 4'($urandom_range(0, 4));
      req_op1   = 4'($urandom_range(0, 4));
      req_a0    = ($urandom_range(0, 5) == 0) ? 8'd0 : N'($urandom);
      req_b0    = ($urandom_range(0, 5) == 0) ? 8'd0 : N'($urandom);
      req_a1    = ($urandom_range(0, 5) == 0) ? 8'd0 : N'($urandom);
      req_b1    = ($urandom_range(0, 5) == 0) ? 8'd0 : N'($urandom);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Two-requester round-robin arbiter and sequencer for the shared registered calculator datapath. Accepts operation requests (op code plus two N-bit operands) over valid/ready handshakes and grants one at a time. Drives the selected operands into the datapath and holds them stable for the datapath's fixed pipeline latency. Captures the 2N-bit result and 4-bit flags, then returns them, tagged with the requester id, over a valid/ready response channel.

## Interface
- N, 8, operand width; result width is 2N
- LAT, 2, datapath latency in cycles from operands presented to result valid (input register plus output register); legal range 1..15
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept strobe; at most one bit high per cycle
- req_op0, req_op1  in  4  op select from requester 0 / 1
- req_a0, req_a1  in  N  operand 1 from requester 0 / 1
- req_b0, req_b1  in  N  operand 2 from requester 0 / 1
- calc_op  out  4  op select to datapath
- calc_a, calc_b  out  N  operands to datapath
- calc_issue  out  1  one-cycle pulse marking the first cycle of a new operation
- calc_result  in  2N  datapath result
- calc_flags  in  4  datapath flags
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that owns the response
- rsp_result  out  2N  captured result
- rsp_flags  out  4  captured flags
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid is set, grant one requester: req_ready[g] = 1 combinationally in that cycle. Latch op/a/b of g into calc_op/calc_a/calc_b and latch g into rsp_id. Go to ISSUE. Otherwise stay in IDLE.
- Arbitration: 1-bit priority pointer `prio`.
  - Both requesters valid: requester `prio` wins.
  - One requester valid: it wins regardless of `prio`.
  - After every grant, `prio` = ~g.
- ISSUE: calc_issue = 1 for exactly this cycle. Load wait counter with LAT-1. Go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture calc_result and calc_flags into rsp_result and rsp_flags, then go to RESP.
- RESP: rsp_valid = 1. rsp_id, rsp_result and rsp_flags stay stable until the cycle in which rsp_ready = 1. In that cycle, go to IDLE.
- calc_op, calc_a and calc_b stay unchanged from the grant edge through the end of RESP. The datapath captures continuously, so they must not change while a result is pending.
- req_ready is 0 in ISSUE, WAIT and RESP. There is no request bypass from RESP to grant.
- Requesters may deassert req_valid before they are granted; no request is recorded until req_ready is high.
- Reset, asserted in any state, takes effect at the next edge:
  - FSM returns to IDLE; `prio` = 0; counter = 0.
  - calc_op, calc_a, calc_b, rsp_id, rsp_result and rsp_flags are cleared to 0.
  - Any in-flight operation is discarded with no response.
- Outputs after reset: req_ready = 0 until a valid request arrives, calc_issue = 0, rsp_valid = 0, busy = 0, all data outputs 0.

## Timing
- Request accepted in cycle t (req_ready high):
  - ISSUE in cycle t+1 (calc_issue high).
  - WAIT in cycles t+2 .. t+1+LAT.
  - Capture at the end of cycle t+1+LAT.
  - rsp_valid first high in cycle t+2+LAT.
- LAT=2: accept at t, response at t+4.
- Maximum throughput, with rsp_ready tied high: one operation per LAT+3 cycles. With LAT=2, the next accept is at t+5.
- rsp_ready low stalls the FSM in RESP indefinitely; nothing is dropped.
- busy = 1 from cycle t+1 through the last RESP cycle.

## Test plan
- Bench datapath model: registered ALU with LAT=2; op 0 gives a+b, op 2 gives a*b; flags bit0 = result zero.
- Reset: assert reset 2 cycles with all req_valid high -> the cycle after deassertion, rsp_valid=0, calc_issue=0, busy=0, calc_a=calc_b=0; in that same cycle req_ready=2'b01, because prio=0 and requester 0 is granted.
- Single request, N=8: requester 0, op=2, a=12, b=10, rsp_ready=1 -> req_ready[0] high at t, calc_issue at t+1, rsp_valid at t+4 with rsp_result=16'd120, rsp_id=0, rsp_flags[0]=0.
- Contention: both requesters valid from reset, requester 0 op 0 with 3+4, requester 1 op 0 with 0+0 -> first response id 0 / result 7; second response id 1 / result 0 / flags[0]=1; second accept exactly 5 cycles after the first.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid rises -> rsp_id, rsp_result, rsp_flags and calc_a/calc_b stable throughout; req_ready=2'b00 despite both requesters valid; returns to IDLE the cycle after rsp_ready rises.
- Reset mid-operation: assert reset during the first WAIT cycle -> next cycle state IDLE, busy=0, rsp_valid never asserts for that request, prio=0.
- Same requester back-to-back: requester 1 only, two requests of 200*200 -> both rsp_result=16'd40000 with rsp_id=1; accepts 5 cycles apart; prio=0 after each grant.
